// File: rtl/krv_uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and parity modes
// used by both the receiver and the transmitter.
package krv_uart_pkg;

  localparam int unsigned UART_OVS_DEFAULT = 16;
  localparam int unsigned UART_DATA_BITS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_mode_e;

  // Parity bit a transmitter appends for the given data and mode.
  function automatic logic uart_parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                           input logic                      odd);
    return (^data) ^ (parity_mode_e'(odd) == PARITY_ODD);
  endfunction

endpackage

// File: rtl/krv_uart_baud_tick.sv
// Oversample tick generator: divisor down-counter with a synchronous reload so
// sampling can be re-aligned to a detected start edge.
module krv_uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 reload_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] load_val;

  always_comb begin
    load_val = (div_i == '0) ? '0 : div_i - DIV_WIDTH'(1);
    cnt_d    = cnt_q;
    if (reload_i || cnt_q == '0) begin
      cnt_d = load_val;
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/krv_uart_rx.sv
// UART receiver: 8N1/8E1/8O1 frames with OVS-times oversampling, delivered to
// the bus through a one-entry holding register with valid/ready handshake.
module krv_uart_rx
  import krv_uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned OVS         = UART_OVS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 cpu_clk,
  input  logic                 porn,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx_en,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 uart_rx,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 rx_busy
);

  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      rxs, rxs_d_q;
  logic                      tick, reload;

  uart_state_e               state_q, state_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      perr_q, perr_d;

  logic                      done_q, done_d;
  logic [UART_DATA_BITS-1:0] pdata_q, pdata_d;
  logic                      pferr_q, pferr_d, pperr_q, pperr_d;

  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d, perr_out_q, perr_out_d;
  logic                      ovr_q, ovr_d;
  logic                      rd, ovr_set, full_pt;

  krv_uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk_i    (cpu_clk),
    .rst_ni   (porn),
    .div_i    (baud_div),
    .reload_i (reload),
    .tick_o   (tick)
  );

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    pdata_d = pdata_q;
    pferr_d = pferr_q;
    pperr_d = pperr_q;
    reload  = 1'b0;
    full_pt = tick && (tcnt_q == FULL_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (rx_en && rxs_d_q && !rxs) begin
          state_d = ST_START;
          tcnt_d  = '0;
          reload  = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt_q == HALF_LAST) begin
            tcnt_d = '0;
            if (!rxs) begin
              state_d = ST_DATA;
              bit_d   = '0;
              perr_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (full_pt) begin
          shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
            state_d = parity_en ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (full_pt) begin
          perr_d  = (rxs != uart_parity_bit(shift_q, parity_odd));
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (full_pt) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          pdata_d = shift_q;
          pferr_d = !rxs;
          pperr_d = perr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counting in the bit states wraps naturally at OVS ticks.
    if (tick && (state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP)) begin
      tcnt_d = full_pt ? '0 : tcnt_q + TW'(1);
    end

    if (!rx_en) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    rd         = valid_q && rx_ready;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;
    ovr_set    = 1'b0;
    if (done_q) begin
      if (!valid_q || rd) begin
        data_d     = pdata_q;
        ferr_d     = pferr_q;
        perr_out_d = pperr_q;
        valid_d    = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rd) begin
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      perr_out_d = 1'b0;
    end
    ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge cpu_clk) begin
    if (!porn) begin
      sync_q     <= '1;
      rxs_d_q    <= 1'b1;
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      done_q     <= 1'b0;
      pdata_q    <= '0;
      pferr_q    <= 1'b0;
      pperr_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= (sync_q << 1) | SYNC_STAGES'(uart_rx);
      rxs_d_q    <= rxs;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      done_q     <= done_d;
      pdata_q    <= pdata_d;
      pferr_q    <= pferr_d;
      pperr_q    <= pperr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_out_q;
  assign overrun    = ovr_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule
